// File: rtl/raifes_src_a_pipe.sv
// Execute-stage ALU operand-A select with EX/WB forwarding, registered output and one-entry skid buffer.
// Optional forwarding-event counter enabled by defining RAIFES_SRC_A_FWD_CNT_EN.
module raifes_src_a_pipe #(
  parameter int XPR_LEN        = 32,
  parameter int SEL_WIDTH      = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      kill,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_WIDTH-1:0]      src_a_sel,
  input  logic [XPR_LEN-1:0]        PC_DX,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [XPR_LEN-1:0]        rs1_data,
  input  logic [XPR_LEN-1:0]        imm,
  input  logic                      ex_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_waddr,
  input  logic [XPR_LEN-1:0]        ex_wdata,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [XPR_LEN-1:0]        wb_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XPR_LEN-1:0]        alu_src_a,
  output logic [31:0]               fwd_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state, state_next;

  logic               accept;
  logic               rs1_nonzero;
  logic               ex_hit;
  logic               wb_hit;
  logic               fwd_event;
  logic [XPR_LEN-1:0] rs1_fwd;
  logic [XPR_LEN-1:0] sel_data;
  logic [XPR_LEN-1:0] out_data;
  logic [XPR_LEN-1:0] skid_data;
  logic               load_out_new;
  logic               load_out_skid;
  logic               load_skid;

  // Both handshake outputs decode the state register only, so neither has a
  // combinational path from out_ready.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_SKID);
  assign alu_src_a = out_data;
  assign accept    = in_valid && in_ready;

  assign rs1_nonzero = (rs1_addr != '0);
  assign ex_hit      = rs1_nonzero && ex_wen && (ex_waddr == rs1_addr);
  assign wb_hit      = rs1_nonzero && wb_wen && (wb_waddr == rs1_addr);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rs1_fwd = rs1_data;
    if (!rs1_nonzero) rs1_fwd = '0;
    else if (ex_hit)  rs1_fwd = ex_wdata;
    else if (wb_hit)  rs1_fwd = wb_wdata;
  end

  always_comb begin
    sel_data = '0;
    case (src_a_sel)
      SEL_WIDTH'(0): sel_data = rs1_fwd;
      SEL_WIDTH'(1): sel_data = PC_DX;
      SEL_WIDTH'(2): sel_data = imm;
      default:       sel_data = '0;
    endcase
  end

  // A forward event is counted at acceptance, even if kill drops the request.
  assign fwd_event = accept && (src_a_sel == SEL_WIDTH'(0)) && (ex_hit || wb_hit);

  always_comb begin
    state_next    = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (kill) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_FULL;
            load_out_new = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready && accept) begin
            load_out_new = 1'b1;
          end else if (out_ready) begin
            state_next = ST_EMPTY;
          end else if (accept) begin
            state_next = ST_SKID;
            load_skid  = 1'b1;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state_next    = ST_FULL;
            load_out_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state <= state_next;
      if (load_out_new)       out_data <= sel_data;
      else if (load_out_skid) out_data <= skid_data;
      if (load_skid)          skid_data <= sel_data;
    end
  end

`ifdef RAIFES_SRC_A_FWD_CNT_EN
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_q <= '0;
    end else if (fwd_event && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign fwd_count = fwd_cnt_q;
`else
  logic unused_fwd_event;
  assign unused_fwd_event = fwd_event;
  assign fwd_count        = 32'd0;
`endif

endmodule

// File: tb/tb_raifes_src_a_pipe.sv
// Directed scoreboard bench for raifes_src_a_pipe: operands are queued at acceptance
// and compared in order when the output stage presents them.
module tb_raifes_src_a_pipe;

  localparam int XPR_LEN = 32;
  localparam int SEL_W   = 2;
  localparam int RA_W    = 5;

  logic              clk = 1'b0;
  logic              reset, kill, in_valid, in_ready, out_valid, out_ready;
  logic [SEL_W-1:0]  src_a_sel;
  logic [XPR_LEN-1:0] pc_dx, rs1_data, imm, ex_wdata, wb_wdata, alu_src_a;
  logic [RA_W-1:0]   rs1_addr, ex_waddr, wb_waddr;
  logic              ex_wen, wb_wen;
  logic [31:0]       fwd_count;

  logic [XPR_LEN-1:0] sb_q[$];
  logic [31:0]        fwd_exp;
  int                 n_vec = 0;
  int                 n_err = 0;

  always #5 clk = ~clk;

  raifes_src_a_pipe #(.XPR_LEN(XPR_LEN), .SEL_WIDTH(SEL_W), .REG_ADDR_WIDTH(RA_W)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_a_sel(src_a_sel), .PC_DX(pc_dx),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .imm(imm),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_src_a(alu_src_a), .fwd_count(fwd_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference operand for the currently driven request.
  function automatic logic [XPR_LEN-1:0] model_operand();
    logic [XPR_LEN-1:0] r;
    case (src_a_sel)
      2'd0: begin
        if (rs1_addr == 0)                           r = '0;
        else if (ex_wen && (ex_waddr == rs1_addr))   r = ex_wdata;
        else if (wb_wen && (wb_waddr == rs1_addr))   r = wb_wdata;
        else                                         r = rs1_data;
      end
      2'd1:    r = pc_dx;
      2'd2:    r = imm;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit model_fwd();
    return (src_a_sel == 2'd0) && (rs1_addr != 0) &&
           ((ex_wen && ex_waddr == rs1_addr) || (wb_wen && wb_waddr == rs1_addr));
  endfunction

  // Called between edges: check outputs, update the scoreboard for this cycle, advance one clock.
  task automatic tick();
    bit acc, cons;
    if (!reset) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, sb_q.size() < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
      if (sb_q.size() != 0) check("alu_src_a", alu_src_a, sb_q[0]);
`ifdef RAIFES_SRC_A_FWD_CNT_EN
      check("fwd_count", fwd_count, fwd_exp);
`else
      check("fwd_count", fwd_count, 32'd0);
`endif
      acc  = in_valid && (sb_q.size() < 2);
      cons = out_ready && (sb_q.size() != 0);
      if (cons) void'(sb_q.pop_front());
      if (acc) begin
        if (model_fwd() && fwd_exp != 32'hFFFF_FFFF) fwd_exp++;
        if (!kill) sb_q.push_back(model_operand());
      end
      if (kill) sb_q.delete();
    end else begin
      sb_q.delete();
      fwd_exp = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req_rs1(input logic [RA_W-1:0] a, input logic [XPR_LEN-1:0] d);
    in_valid = 1'b1; src_a_sel = 2'd0; rs1_addr = a; rs1_data = d;
  endtask

  task automatic req_imm(input logic [XPR_LEN-1:0] v);
    in_valid = 1'b1; src_a_sel = 2'd2; imm = v;
  endtask

  initial begin
    reset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src_a_sel = '0; pc_dx = '0; rs1_addr = '0; rs1_data = '0; imm = '0;
    ex_wen = 1'b0; ex_waddr = '0; ex_wdata = '0;
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    fwd_exp = 0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_alu_src_a", alu_src_a, 32'd0);
    check("rst_fwd_count", fwd_count, 32'd0);

    // PC select, one-cycle latency.
    out_ready = 1'b1; in_valid = 1'b1; src_a_sel = 2'd1; pc_dx = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    check("pc_latency_valid", {31'd0, out_valid}, 32'd1);
    check("pc_latency_data", alu_src_a, 32'h0000_0100);
    tick();

    // Forwarding priority EX > WB > regfile, x0 never forwarded.
    ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h22;
    wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h33;
    req_rs1(5'd5, 32'h11); tick();
    ex_wen = 1'b0;         tick();
    req_rs1(5'd0, 32'h11); tick();
    wb_wen = 1'b0;
    req_rs1(5'd7, 32'h44); tick();
    in_valid = 1'b0;       tick();

    // Backpressure: A then B, then drain in order.
    out_ready = 1'b0;
    req_imm(32'hA); tick();
    req_imm(32'hB); tick();
    in_valid = 1'b0;
    check("skid_in_ready", {31'd0, in_ready}, 32'd0);
    imm = 32'hDEAD; ex_wen = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'hBAD;
    tick(); tick();
    out_ready = 1'b1;
    tick(); tick(); tick();
    ex_wen = 1'b0;

    // Kill in SKID with a request pending: all dropped.
    out_ready = 1'b0;
    req_imm(32'hC1); tick();
    req_imm(32'hC2); tick();
    kill = 1'b1; req_imm(32'hC3); tick();
    kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("kill_out_valid", {31'd0, out_valid}, 32'd0);
    check("kill_in_ready",  {31'd0, in_ready},  32'd1);
    tick(); tick();

    // Kill in FULL drops a same-cycle forwarded RS1 request, which still counts.
    out_ready = 1'b0;
    req_imm(32'hD1); tick();
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h55;
    kill = 1'b1; req_rs1(5'd3, 32'h66); tick();
    kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_wen = 1'b0;
    tick(); tick();

    // Illegal/zero select code.
    in_valid = 1'b1; src_a_sel = 2'd3; rs1_data = 32'hFFFF_FFFF; imm = 32'h1234; pc_dx = 32'h5678;
    tick();
    in_valid = 1'b0;
    check("sel_zero", alu_src_a, 32'd0);
    tick();

    // Counter mix: 4 EX-forwarded, 2 WB-forwarded, 3 plain.
    ex_wen = 1'b1; ex_waddr = 5'd10; ex_wdata = 32'hE0;
    wb_wen = 1'b1; wb_waddr = 5'd11; wb_wdata = 32'hB0;
    for (int i = 0; i < 4; i++) begin req_rs1(5'd10, 32'h100 + i); tick(); end
    for (int i = 0; i < 2; i++) begin req_rs1(5'd11, 32'h200 + i); tick(); end
    for (int i = 0; i < 3; i++) begin req_rs1(5'd12, 32'h300 + i); tick(); end
    in_valid = 1'b0; tick();

    // Random handshake traffic through the output stage.
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      src_a_sel = 2'($urandom_range(0, 3));
      rs1_addr  = 5'($urandom_range(0, 3));
      ex_waddr  = 5'($urandom_range(0, 3));
      wb_waddr  = 5'($urandom_range(0, 3));
      ex_wen    = 1'($urandom_range(0, 1));
      wb_wen    = 1'($urandom_range(0, 1));
      rs1_data  = $urandom; imm = $urandom; pc_dx = $urandom;
      ex_wdata  = $urandom; wb_wdata = $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/raifes_src_a_pipe.md
Name: raifes_src_a_pipe

Overview:
- Parametrised, pipelined successor to the ALU operand-A select in the execute stage.
- Selects operand A from RS1, PC, immediate or zero, and resolves RAW hazards by forwarding from the EX and WB stages.
- Registers the result into a one-deep output stage backed by a one-entry skid buffer, under a valid/ready handshake.
- Sits between decode/regfile read and the ALU; supports flush (kill) from branch/exception logic.

Parameters:
- XPR_LEN, 32, operand/data width in bits.
- SEL_WIDTH, 2, width of the source-select field.
- REG_ADDR_WIDTH, 5, register address width.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- kill  input  1  flush; drops all held operands.
- in_valid  input  1  upstream operand request valid.
- in_ready  output  1  block can accept a request this cycle.
- src_a_sel  input  SEL_WIDTH  0=RS1, 1=PC, 2=IMM, 3=ZERO; other codes give 0.
- PC_DX  input  XPR_LEN  PC of the instruction in decode.
- rs1_addr  input  REG_ADDR_WIDTH  RS1 register index.
- rs1_data  input  XPR_LEN  regfile read data for RS1.
- imm  input  XPR_LEN  sign-extended immediate.
- ex_wen  input  1  EX stage will write a register.
- ex_waddr  input  REG_ADDR_WIDTH  EX destination register.
- ex_wdata  input  XPR_LEN  EX result.
- wb_wen  input  1  WB stage writing a register.
- wb_waddr  input  REG_ADDR_WIDTH  WB destination register.
- wb_wdata  input  XPR_LEN  WB result.
- out_valid  output  1  alu_src_a is valid.
- out_ready  input  1  ALU consumes the operand.
- alu_src_a  output  XPR_LEN  registered operand A.
- fwd_count  output  32  forwarding event counter (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): out_valid=0, alu_src_a=0, skid buffer empty, in_ready=1, fwd_count=0.
- Request acceptance: a request is accepted when in_valid && in_ready.
- Operand selection (combinational, at acceptance):
  - RS1 value is forwarded with priority EX > WB > rs1_data.
  - EX forwarding applies when ex_wen && ex_waddr==rs1_addr && rs1_addr!=0.
  - WB forwarding applies under the same rule using wb_wen/wb_waddr.
  - Register x0 always reads 0, with no forwarding.
  - PC, IMM and ZERO selections ignore forwarding and never count as forward events.
- Latency: an accepted request appears on alu_src_a with out_valid=1 in the next cycle (1-cycle latency).
- Output-stage occupancy:
  - States: EMPTY (out_valid=0), FULL (out_valid=1, skid empty), SKID (out_valid=1, skid holds one).
  - EMPTY: accept -> FULL.
  - FULL:
    - out_ready && accept -> FULL with new data.
    - out_ready && !accept -> EMPTY.
    - !out_ready && accept -> SKID; the new operand goes into skid.
    - !out_ready && !accept -> hold.
  - SKID: in_ready=0.
    - out_ready -> skid moves to output, state FULL.
    - otherwise hold.
- in_ready is registered: in_ready = (state != SKID). in_ready never depends combinationally on out_ready.
- alu_src_a is stable while out_valid && !out_ready.
- Forwarding values are captured at acceptance. Later changes to ex_*/wb_* do not alter held operands.
- kill: next state EMPTY, skid cleared, alu_src_a unchanged (don't care). A request accepted in the same cycle is dropped. kill has priority over all transitions.
- reset has priority over kill.
- Arithmetic: none beyond selection. All widths are exactly XPR_LEN with no extension.

Optional Feature:
- Macro: RAIFES_SRC_A_FWD_CNT_EN.
- Defined:
  - fwd_count increments by 1 for each accepted RS1 request resolved from EX or WB, including requests dropped by kill in the same cycle.
  - The counter saturates at 32'hFFFFFFFF.
  - Cleared only by reset.
- Undefined: fwd_count is tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset, then sel=1, PC_DX=0x0000_0100, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_src_a=0x100.
- Forward priority: sel=0, rs1_addr=5, rs1_data=0x11, ex_wen=1 ex_waddr=5 ex_wdata=0x22, wb_wen=1 wb_waddr=5 wb_wdata=0x33 -> alu_src_a=0x22. Repeat with ex_wen=0 -> 0x33. With rs1_addr=0 -> 0.
- Backpressure: out_ready=0, accept A=0xA then B=0xB on consecutive cycles -> output holds 0xA, in_ready=0 after B. Raise out_ready -> 0xA then 0xB are delivered in order, with no loss or duplication.
- Kill: in SKID state assert kill with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no stale operand appears later.
- Illegal sel=3 (with SEL_WIDTH=3, sel=5) -> alu_src_a=0.
- Counter (macro defined): 4 EX-forwarded, 2 WB-forwarded, 3 non-forwarded requests -> fwd_count=6. Macro undefined -> fwd_count stays 0.
